// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: control-unit encodings
// for brtype/pcsrc, the fetch FSM state type and instruction field positions.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_BLTZ = 2'b11
  } brtype_e;

  typedef enum logic [1:0] {
    PC_SEQ     = 2'b00,
    PC_JUMP    = 2'b01,
    PC_JR      = 2'b10,
    PC_SYSCALL = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    REQ   = 2'b00,
    WAIT  = 2'b01,
    ISSUE = 2'b10
  } state_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FN_MSB    = 5;
  localparam int FN_LSB    = 0;
  localparam int IMM_MSB   = 15;
  localparam int JTGT_MSB  = 25;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack handshake.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : word-aligned fetch address
//   imem_ack   : imem_rdata valid this cycle
//   imem_rdata : instruction word
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection for the instruction in ISSUE.
//   pc_plus4_i, instr_i      : current instruction context
//   brtype_i, pcsrc_i        : control-unit decode
//   rs_data_i, rt_data_i     : register operands (compare, JR target)
//   next_pc_o                : address of the following fetch
//   jr_misalign_o            : JR target had nonzero low bits
module next_pc_logic
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] SYSCALL_VEC = 32'h0000_0080
) (
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  input  logic [1:0]  brtype_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] next_pc_o,
  output logic        jr_misalign_o
);

  logic        taken;
  logic [31:0] br_off;

  assign br_off = {{14{instr_i[IMM_MSB]}}, instr_i[IMM_MSB:0], 2'b00};

  always_comb begin
    taken = 1'b0;
    case (brtype_i)
      BR_BEQ:  taken = (rs_data_i == rt_data_i);
      BR_BNE:  taken = (rs_data_i != rt_data_i);
      BR_BLTZ: taken = rs_data_i[31];
      default: taken = 1'b0;
    endcase
  end

  // Unmatched (including unknown) pcsrc falls through to sequential.
  always_comb begin
    next_pc_o     = pc_plus4_i;
    jr_misalign_o = 1'b0;
    case (pcsrc_i)
      PC_SEQ:     if (taken) next_pc_o = pc_plus4_i + br_off;
      PC_JUMP:    next_pc_o = {pc_plus4_i[31:28], instr_i[JTGT_MSB:0], 2'b00};
      PC_JR: begin
        next_pc_o     = {rs_data_i[31:2], 2'b00};
        jr_misalign_o = |rs_data_i[1:0];
      end
      PC_SYSCALL: next_pc_o = SYSCALL_VEC;
      default:    next_pc_o = pc_plus4_i;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, instruction register and EPC, runs the
// REQ/WAIT/ISSUE handshake with instruction memory and advances the PC
// when the datapath releases stall.
//   clk, rst          : clock, async active-high reset
//   imem              : instruction-memory handshake (master side)
//   stall_i           : hold the current instruction
//   brtype_i, pcsrc_i : control-unit decode of the issued instruction
//   rs_data_i, rt_data_i : register operands
//   ir_valid_o, instr_o and field slices : issued instruction
//   pc_o, pc_plus4_o, epc_o, misalign_o  : PC state and JR fault pulse
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] SYSCALL_VEC = 32'h0000_0080
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_unit_if.master        imem,
  input  logic                      stall_i,
  input  logic [1:0]                brtype_i,
  input  logic [1:0]                pcsrc_i,
  input  logic [31:0]               rs_data_i,
  input  logic [31:0]               rt_data_i,
  output logic                      ir_valid_o,
  output logic [31:0]               instr_o,
  output logic [5:0]                op_o,
  output logic [5:0]                fn_o,
  output logic [4:0]                rs_o,
  output logic [4:0]                rt_o,
  output logic [4:0]                rd_o,
  output logic [15:0]               imm16_o,
  output logic [31:0]               pc_o,
  output logic [31:0]               pc_plus4_o,
  output logic [31:0]               epc_o,
  output logic                      misalign_o
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] epc_q;
  logic        misalign_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc_d;
  logic        jr_misalign;

  assign pc_plus4 = pc_q + PC_STEP;

  next_pc_logic #(.SYSCALL_VEC(SYSCALL_VEC)) u_next_pc (
    .pc_plus4_i    (pc_plus4),
    .instr_i       (instr_q),
    .brtype_i      (brtype_i),
    .pcsrc_i       (pcsrc_i),
    .rs_data_i     (rs_data_i),
    .rt_data_i     (rt_data_i),
    .next_pc_o     (next_pc_d),
    .jr_misalign_o (jr_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        REQ: begin
          // Zero-wait memory may ack in the request cycle itself.
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            state_q <= ISSUE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall_i) begin
            pc_q       <= next_pc_d;
            misalign_q <= jr_misalign;
            if (pcsrc_i == PC_SYSCALL) epc_q <= pc_plus4;
            state_q    <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  // Request is a decode of the state register; gating with rst keeps it low
  // while reset is held even though the state already reads REQ.
  assign imem.imem_req  = (state_q != ISSUE) && !rst;
  assign imem.imem_addr = {pc_q[31:2], 2'b00};

  assign ir_valid_o = (state_q == ISSUE);
  assign instr_o    = instr_q;
  assign op_o       = instr_q[OP_MSB:OP_LSB];
  assign fn_o       = instr_q[FN_MSB:FN_LSB];
  assign rs_o       = instr_q[RS_MSB:RS_LSB];
  assign rt_o       = instr_q[RT_MSB:RT_LSB];
  assign rd_o       = instr_q[RD_MSB:RD_LSB];
  assign imm16_o    = instr_q[IMM_MSB:0];
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;
  assign epc_o      = epc_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  brtype = 2'b00;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        ir_valid;
  logic [31:0] instr;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] pc, pc_plus4, epc;
  logic        misalign;

  instr_fetch_unit_if imem_if();

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_if),
    .stall_i    (stall),
    .brtype_i   (brtype),
    .pcsrc_i    (pcsrc),
    .rs_data_i  (rs_data),
    .rt_data_i  (rt_data),
    .ir_valid_o (ir_valid),
    .instr_o    (instr),
    .op_o       (op),
    .fn_o       (fn),
    .rs_o       (rs),
    .rt_o       (rt),
    .rd_o       (rd),
    .imm16_o    (imm16),
    .pc_o       (pc),
    .pc_plus4_o (pc_plus4),
    .epc_o      (epc),
    .misalign_o (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iw;
    logic [31:0] pc;
    int          cycles;
  } issue_t;

  typedef struct {
    logic        mis;
    logic [31:0] epc;
  } retire_t;

  issue_t      issue_q[$];
  retire_t     retire_q[$];
  logic [31:0] addr_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_pc  = 32'h0;
  logic [31:0] model_epc = 32'h0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: next fetch address from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] iw,
                                             input logic [1:0] br, input logic [1:0] pcs,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p4;
    logic [31:0] off;
    bit          taken;
    p4 = cur_pc + 32'd4;
    case (pcs)
      2'd1: return (p4 & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
      2'd2: return a & ~32'd3;
      2'd3: return 32'h0000_0080;
      default: begin
        taken = (br == 2'd1 && a == b) || (br == 2'd2 && a != b) || (br == 2'd3 && $signed(a) < 0);
        off = 32'(int'($signed(iw[15:0])) * 4);
        return taken ? p4 + off : p4;
      end
    endcase
  endfunction

  // One instruction: memory latency, optional stall with noise, then release.
  task automatic do_instr(input logic [31:0] iw, input logic [1:0] br, input logic [1:0] pcs,
                          input logic [31:0] a, input logic [31:0] b, input int lat, input int nstall);
    issue_t  ie;
    retire_t re;
    logic [31:0] nxt;
    repeat (lat) @(negedge clk);
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = iw;
    ie.iw = iw; ie.pc = model_pc; ie.cycles = nstall + 1;
    issue_q.push_back(ie);
    @(negedge clk);
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = $urandom;
    for (int k = 0; k < nstall; k++) begin
      stall   = 1'b1;
      brtype  = 2'($urandom);
      pcsrc   = 2'($urandom);
      rs_data = $urandom;
      rt_data = $urandom;
      imem_if.imem_ack = 1'($urandom);
      @(negedge clk);
    end
    imem_if.imem_ack = 1'b0;
    stall   = 1'b0;
    brtype  = br;
    pcsrc   = pcs;
    rs_data = a;
    rt_data = b;
    nxt = model_next(model_pc, iw, br, pcs, a, b);
    if (pcs == 2'd3) model_epc = model_pc + 32'd4;
    re.mis = (pcs == 2'd2) && (a[1:0] != 2'b00);
    re.epc = model_epc;
    retire_q.push_back(re);
    addr_q.push_back(nxt);
    model_pc = nxt;
    @(negedge clk);
  endtask

  // Monitor / scoreboard
  initial begin
    logic   prev_req = 1'b0;
    logic   prev_ir  = 1'b0;
    int     icount   = 0;
    issue_t cur;
    retire_t re;
    cur.iw = '0; cur.pc = '0; cur.cycles = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev_req = 1'b0;
        prev_ir  = 1'b0;
        continue;
      end
      if (imem_if.imem_req && !prev_req) begin
        if (addr_q.size() == 0) check("unexpected_fetch", imem_if.imem_addr, 32'hXXXX_XXXX);
        else check("fetch_addr", imem_if.imem_addr, addr_q.pop_front());
      end
      if (ir_valid && !prev_ir) begin
        if (issue_q.size() == 0) check("unexpected_issue", instr, 32'hXXXX_XXXX);
        else begin
          cur = issue_q.pop_front();
          icount = 1;
          check("instr", instr, cur.iw);
          check("fields", {op, rs, rt, rd, fn, imm16},
                {6'(cur.iw >> 26), 5'(cur.iw >> 21), 5'(cur.iw >> 16), 5'(cur.iw >> 11), 6'(cur.iw % 64), 16'(cur.iw % 65536)});
          check("pc", pc, cur.pc);
          check("pc_plus4", pc_plus4, cur.pc + 32'd4);
        end
      end else if (ir_valid) begin
        icount++;
        check("hold_instr", instr, cur.iw);
        check("hold_pc", pc, cur.pc);
      end
      if (ir_valid) check("req_in_issue", {31'b0, imem_if.imem_req}, 32'd0);
      if (!ir_valid && prev_ir) begin
        if (retire_q.size() == 0) check("unexpected_retire", {31'b0, misalign}, 32'hXXXX_XXXX);
        else begin
          re = retire_q.pop_front();
          check("misalign", {31'b0, misalign}, {31'b0, re.mis});
          check("epc", epc, re.epc);
          check("issue_cycles", icount, cur.cycles);
        end
      end else begin
        check("misalign_idle", {31'b0, misalign}, 32'd0);
      end
      prev_req = imem_if.imem_req;
      prev_ir  = ir_valid;
    end
  end

  // Stimulus
  initial begin
    logic [31:0] a, b;
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_req", {31'b0, imem_if.imem_req}, 32'd0);
    check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_epc", epc, 32'h0);
    addr_q.push_back(32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_instr(32'h0000_0020, 2'd0, 2'd0, 32'd0, 32'd0, 2, 0);          // ADD @0 -> 4
    do_instr(32'h0800_0004, 2'd0, 2'd1, 32'd0, 32'd0, 0, 0);          // J    -> 0x10
    do_instr(32'h1000_FFFF, 2'd1, 2'd0, 32'd5, 32'd5, 1, 0);          // BEQ taken -> 0x10
    do_instr(32'h1000_FFFF, 2'd1, 2'd0, 32'd5, 32'd6, 0, 0);          // BEQ not -> 0x14
    do_instr(32'h0000_0008, 2'd0, 2'd2, 32'h20, 32'd0, 0, 0);         // JR -> 0x20
    do_instr(32'h0400_0003, 2'd3, 2'd0, 32'h8000_0000, 32'd0, 1, 0);  // BLTZ -> 0x30
    do_instr(32'h0000_0008, 2'd0, 2'd2, 32'h1000_0000, 32'd0, 0, 0);  // JR -> 0x1000_0000
    do_instr(32'h0800_0040, 2'd0, 2'd1, 32'd0, 32'd0, 0, 0);          // J -> 0x1000_0100
    do_instr(32'h0000_0008, 2'd0, 2'd2, 32'h0000_0203, 32'd0, 0, 0);  // JR misaligned -> 0x200
    do_instr(32'h0800_0010, 2'd0, 2'd1, 32'd0, 32'd0, 0, 0);          // J -> 0x40
    do_instr(32'h0000_000C, 2'd0, 2'd3, 32'd0, 32'd0, 0, 0);          // syscall -> 0x80
    do_instr(32'h0000_0020, 2'd0, 2'd0, 32'd0, 32'd0, 0, 5);          // stall 5 -> 0x84
    do_instr(32'h0000_0008, 2'd0, 2'd2, 32'hFFFF_FFFC, 32'd0, 0, 0);  // JR -> top of space
    do_instr(32'h1000_0001, 2'd1, 2'd0, 32'd7, 32'd7, 0, 0);          // wrap + branch -> 4
    do_instr(32'h0000_0020, 2'd2, 2'd3, 32'd1, 32'd2, 0, 0);          // pcsrc over brtype

    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      do_instr($urandom, 2'($urandom), 2'($urandom), a, b, $urandom_range(0, 3),
               ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0);
    end

    // Reset while waiting on memory, with an ack arriving during reset.
    @(negedge clk);
    rst = 1'b1;
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("wrst_req", {31'b0, imem_if.imem_req}, 32'd0);
    check("wrst_pc", pc, 32'h0);
    @(negedge clk);
    check("wrst_instr", instr, 32'h0);
    check("wrst_ir_valid", {31'b0, ir_valid}, 32'd0);
    model_pc  = 32'h0;
    model_epc = 32'h0;
    addr_q.push_back(32'h0);
    imem_if.imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_req", {31'b0, imem_if.imem_req}, 32'd1);
    check("post_rst_addr", imem_if.imem_addr, 32'h0);
    @(negedge clk);
    do_instr(32'h0000_0020, 2'd0, 2'd0, 32'd0, 32'd0, 0, 0);

    repeat (3) @(negedge clk);
    check("issue_q_left", issue_q.size(), 32'd0);
    check("retire_q_left", retire_q.size(), 32'd0);
    check("addr_q_left", addr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the 32-bit control unit. Holds the PC and fetches instruction words through a req/ack instruction-memory handshake. Drives op/fn and register fields to the control unit and datapath. Consumes the control unit's brtype/pcsrc, plus register operands, to compute the next PC. It issues one instruction at a time; the datapath can extend execution with a stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
SYSCALL_VEC, 32'h0000_0080, PC target when pcsrc = 2'b11 (system call).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request, held high until imem_ack
imem_addr  out  32  word-aligned fetch address (bits [1:0] always 00)
imem_ack  in  1  instruction word valid on imem_rdata this cycle
imem_rdata  in  32  instruction word
stall  in  1  datapath not done; hold current instruction
brtype  in  2  from control unit: 00 none, 01 BEQ, 10 BNE, 11 BLTZ
pcsrc  in  2  from control unit: 00 sequential/branch, 01 J/JAL, 10 JR, 11 syscall
rs_data  in  32  register rs value (branch compare, JR target)
rt_data  in  32  register rt value (branch compare)
ir_valid  out  1  instruction register holds a live instruction (ISSUE state)
instr  out  32  instruction register
op  out  6  instr[31:26] to control unit
fn  out  6  instr[5:0] to control unit
rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
imm16  out  16  instr[15:0]
pc  out  32  address of the current instruction
pc_plus4  out  32  pc + 4, used as the JAL link value
epc  out  32  pc_plus4 captured on syscall
misalign  out  1  one-cycle pulse: JR target had bits [1:0] != 0

Behaviour:
- Reset (async, any state or mid-handshake): pc = RESET_PC, instr = 0, epc = 0, imem_req = 0, ir_valid = 0, misalign = 0, state = REQ.
- FSM has 3 states.
- REQ: imem_req = 1, imem_addr = pc. Go to WAIT next cycle. If imem_ack is already high in REQ, capture instr and go to ISSUE directly (zero-wait memory).
- WAIT: imem_req = 1. On imem_ack, instr <= imem_rdata and go to ISSUE. Otherwise stay in WAIT; there is no timeout.
- ISSUE: ir_valid = 1, imem_req = 0.
  - If stall = 1: hold all state. brtype/pcsrc/rs_data/rt_data are ignored.
  - If stall = 0: pc <= next_pc and go to REQ. Fetch-to-fetch minimum is 2 cycles with zero-wait memory.
- imem_ack outside REQ/WAIT is ignored.
- next_pc, evaluated in ISSUE only:
  - pcsrc = 01: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - pcsrc = 10: {rs_data[31:2], 2'b00}; misalign pulses if rs_data[1:0] != 0.
  - pcsrc = 11: SYSCALL_VEC; epc <= pc_plus4 in the same edge.
  - pcsrc = 00: if taken, branch target = pc_plus4 + (sign-extended imm16 << 2); else pc_plus4.
    - BEQ taken when rs_data == rt_data.
    - BNE taken when rs_data != rt_data.
    - BLTZ taken when rs_data[31] = 1.
    - brtype 00 is never taken.
  - pcsrc takes priority over brtype if both are nonzero.
- Arithmetic is 32-bit modulo. pc 32'hFFFF_FFFC + 4 wraps to 0 with no flag; a branch target wraps the same way.
- Unknown (X) control inputs in ISSUE: next_pc = pc_plus4. The control unit outputs X for illegal opcodes.
- misalign is registered: high exactly the cycle after the JR edge, otherwise 0.
- op/fn/rs/rt/rd/imm16 are pure slices of instr. They are valid whenever ir_valid = 1 and hold their last value otherwise.

Decomposition:
- Shared package:
  - brtype encodings: BR_NONE, BR_BEQ, BR_BNE, BR_BLTZ.
  - pcsrc encodings: PC_SEQ, PC_JUMP, PC_JR, PC_SYSCALL.
  - FSM state type: REQ, WAIT, ISSUE.
  - Constants: instruction field bit positions, PC_STEP = 4.
- One combinational sub-module, next_pc_logic. Inputs: pc_plus4, instr, brtype, pcsrc, rs_data, rt_data. Outputs: next_pc, jr_misalign. The top module owns the FSM, the PC/IR/epc registers and the handshake.

Test Plan:
- Reset release, memory acks 2 cycles after req, instr 32'h0000_0020 (ADD), no stall -> imem_addr 0x0, then 0x4; ir_valid high 1 cycle; op = 0, fn = 6'h20.
- BEQ at pc 0x10, imm16 = 16'hFFFF, rs_data = rt_data = 5 -> next imem_addr 0x10. Repeat with rt_data = 6 -> 0x14.
- BLTZ with rs_data = 32'h8000_0000 and imm16 = 3 at pc 0x20 -> 0x30. J at pc 0x1000_0000 with target 26'h40 -> 0x1000_0100.
- JR with rs_data = 32'h0000_0203 -> imem_addr 0x200, misalign pulse 1 cycle. Syscall at pc 0x40 -> imem_addr 0x80, epc = 0x44.
- stall held 5 cycles in ISSUE while brtype/pcsrc/rs_data toggle -> pc and instr unchanged, imem_req = 0, ir_valid = 1. On release, next_pc uses values present in the release cycle.
- rst asserted in WAIT, with ack arriving during reset -> instr stays 0, pc = RESET_PC, imem_req low during reset, new request to RESET_PC the first cycle after release.
